cond_exec_stage: RTL and testbench
==================================

COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU result and store-data paths.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE  input  1 each  execute-stage controls from the decode/execute register.
REQ-005 SHALL have FlagWriteE  input  2  bit1 = write N,Z; bit0 = write C,V.
REQ-006 SHALL have CondE  input  4  instruction condition field.
REQ-007 SHALL have FlagsE  input  4  {N,Z,C,V} the condition is tested against.
REQ-008 SHALL have ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-009 SHALL have ALUResultE, WriteDataE  input  DATA_W each  execute datapath values.
REQ-010 SHALL have WA3E  input  4  destination register index.
REQ-011 SHALL have StallM  input  1  hold execute/memory register and flag register.
REQ-012 SHALL have FlushM  input  1  kill the execute-stage instruction.
REQ-013 SHALL have PCSrcM, RegWriteM, MemtoRegM, MemWriteM  output  1 each  registered gated controls.
REQ-014 SHALL have ALUResultM, WriteDataM  output  DATA_W each; WA3M  output  4; all registered.
REQ-015 SHALL have Flags  output  4  current flag register {N,Z,C,V}, fed back to decode.
REQ-016 SHALL have CondExE  output  1 and BranchTakenE  output  1, both combinational.

Function
REQ-017 CondExE SHALL decode CondE on FlagsE: 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V; 8 C&!Z; 9 !C|Z; A N==V; B N!=V; C !Z&(N==V); D Z|(N!=V); E 1; F 0.
REQ-018 BranchTakenE SHALL equal BranchE & CondExE & !FlushM, same cycle, zero latency.
REQ-019 Flag register SHALL update on a clock edge only when CondExE=1, FlushM=0, StallM=0: FlagWriteE[1] loads N,Z from ALUFlags[3:2]; FlagWriteE[0] loads C,V from ALUFlags[1:0]; unselected bits hold.
REQ-020 Execute/memory register priority per edge SHALL be: reset > FlushM > StallM > load.
REQ-021 On load: PCSrcM<=PCSrcE&CondExE; RegWriteM<=RegWriteE&CondExE; MemWriteM<=MemWriteE&CondExE; MemtoRegM<=MemtoRegE; ALUResultM, WriteDataM, WA3M <= E values.
REQ-022 On FlushM=1 (regardless of StallM): all M control outputs SHALL become 0 next edge; data outputs SHALL become 0.
REQ-023 On StallM=1, FlushM=0: all M outputs and Flags SHALL hold.
REQ-024 Latency E->M SHALL be exactly one clock; Flags output SHALL reflect an update one clock after the qualifying edge input.
REQ-025 Failed condition SHALL suppress all architectural side effects (register write, memory write, PC write, flag write) but still advance data fields.
REQ-026 Flags SHALL be output directly from the register, no bypass from ALUFlags.

Reset
REQ-027 Asserting reset SHALL immediately clear all M outputs, data outputs, WA3M and Flags to 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight instruction; first edge after deassertion SHALL perform a normal load.
REQ-029 CondExE and BranchTakenE SHALL remain purely functions of current inputs during reset.

Verification
REQ-030 CondE=0 (EQ), FlagsE=0100, RegWriteE=1, WA3E=5 -> CondExE=1, next edge RegWriteM=1, WA3M=5; FlagsE=0000 -> RegWriteM=0.
REQ-031 Sweep all 16 CondE x 16 FlagsE -> CondExE matches REQ-017 table in all 256 cases; CondE=F always 0.
REQ-032 CondE=E, FlagWriteE=10, ALUFlags=1111, Flags=0000 -> next edge Flags=1100; then FlagWriteE=01 -> Flags=1111.
REQ-033 CondE=E, MemWriteE=1, StallM=1 for 3 cycles -> MemWriteM and Flags hold previous values for 3 edges; FlushM=1 with StallM=1 -> MemWriteM=0, Flags unchanged.
REQ-034 BranchE=1, PCSrcE=1, CondE=1, FlagsE Z=0 -> BranchTakenE=1 same cycle, PCSrcM=1 next edge; FlushM=1 same cycle -> BranchTakenE=0, PCSrcM=0.
REQ-035 Load ALUResultE=0xDEADBEEF, Flags=1010, assert reset between edges -> ALUResultM=0, Flags=0000 immediately before next edge.

Source files
------------

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - execute-stage condition check, flag register and E->M pipeline register
module cond_exec_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic [1:0]        FlagWriteE,
  input  logic [3:0]        CondE,
  input  logic [3:0]        FlagsE,
  input  logic [3:0]        ALUFlags,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [3:0]        WA3E,
  input  logic              StallM,
  input  logic              FlushM,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [3:0]        WA3M,
  output logic [3:0]        Flags,
  output logic              CondExE,
  output logic              BranchTakenE
);

  logic n_e, z_e, c_e, v_e;
  logic [3:0] flags_q, flags_d;
  logic       flag_we;

  logic              pcsrc_q, regwrite_q, memtoreg_q, memwrite_q;
  logic [DATA_W-1:0] alu_q, wd_q;
  logic [3:0]        wa3_q;

  assign {n_e, z_e, c_e, v_e} = FlagsE;

  always_comb begin
    CondExE = 1'b0;
    unique case (CondE)
      4'h0: CondExE = z_e;
      4'h1: CondExE = ~z_e;
      4'h2: CondExE = c_e;
      4'h3: CondExE = ~c_e;
      4'h4: CondExE = n_e;
      4'h5: CondExE = ~n_e;
      4'h6: CondExE = v_e;
      4'h7: CondExE = ~v_e;
      4'h8: CondExE = c_e & ~z_e;
      4'h9: CondExE = ~c_e | z_e;
      4'hA: CondExE = (n_e == v_e);
      4'hB: CondExE = (n_e != v_e);
      4'hC: CondExE = ~z_e & (n_e == v_e);
      4'hD: CondExE = z_e | (n_e != v_e);
      4'hE: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end

  assign BranchTakenE = BranchE & CondExE & ~FlushM;

  // Flags only commit for an instruction that executes and actually leaves execute
  assign flag_we = CondExE & ~FlushM & ~StallM;

  always_comb begin
    flags_d = flags_q;
    if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
    if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alu_q      <= '0;
      wd_q       <= '0;
      wa3_q      <= 4'h0;
    end else if (FlushM) begin
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alu_q      <= '0;
      wd_q       <= '0;
      wa3_q      <= 4'h0;
    end else if (!StallM) begin
      pcsrc_q    <= PCSrcE & CondExE;
      regwrite_q <= RegWriteE & CondExE;
      memtoreg_q <= MemtoRegE;
      memwrite_q <= MemWriteE & CondExE;
      alu_q      <= ALUResultE;
      wd_q       <= WriteDataE;
      wa3_q      <= WA3E;
    end
  end

  assign PCSrcM     = pcsrc_q;
  assign RegWriteM  = regwrite_q;
  assign MemtoRegM  = memtoreg_q;
  assign MemWriteM  = memwrite_q;
  assign ALUResultM = alu_q;
  assign WriteDataM = wd_q;
  assign WA3M       = wa3_q;
  assign Flags      = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - scoreboard bench for cond_exec_stage with randomized and directed stimulus
module tb_cond_exec_stage;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE;
  logic [1:0] FlagWriteE;
  logic [3:0] CondE, FlagsE, ALUFlags, WA3E;
  logic [DW-1:0] ALUResultE, WriteDataE;
  logic StallM, FlushM;
  logic PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [DW-1:0] ALUResultM, WriteDataM;
  logic [3:0] WA3M, Flags;
  logic CondExE, BranchTakenE;

  cond_exec_stage #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .FlagsE(FlagsE), .ALUFlags(ALUFlags),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .StallM(StallM), .FlushM(FlushM),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .WA3M(WA3M), .Flags(Flags), .CondExE(CondExE), .BranchTakenE(BranchTakenE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcsrc, regwrite, memtoreg, memwrite, branch;
    logic [1:0] fw;
    logic [3:0] cond, flags_e, alu_flags, wa3;
    logic [DW-1:0] alu, wd;
    logic stall, flush;
  } stim_t;

  typedef struct packed {
    logic pcsrc, regwrite, memtoreg, memwrite;
    logic [DW-1:0] alu, wd;
    logic [3:0] wa3, flags;
  } mstate_t;

  mstate_t exp_q[$];
  mstate_t model;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each condition code, written from the mnemonics
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;                   // EQ
      4'h1: return !z;                  // NE
      4'h2: return cc;                  // CS
      4'h3: return !cc;                 // CC
      4'h4: return n;                   // MI
      4'h5: return !n;                  // PL
      4'h6: return v;                   // VS
      4'h7: return !v;                  // VC
      4'h8: return cc && !z;            // HI
      4'h9: return !(cc && !z);         // LS
      4'hA: return n == v;              // GE
      4'hB: return !(n == v);           // LT
      4'hC: return !z && (n == v);      // GT
      4'hD: return !(!z && (n == v));   // LE
      4'hE: return 1'b1;                // AL
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.cond = 4'hE;
    return s;
  endfunction

  task automatic step(input stim_t s);
    logic ce;
    @(negedge clk);
    reset = 1'b0;
    PCSrcE = s.pcsrc; RegWriteE = s.regwrite; MemtoRegE = s.memtoreg;
    MemWriteE = s.memwrite; BranchE = s.branch; FlagWriteE = s.fw;
    CondE = s.cond; FlagsE = s.flags_e; ALUFlags = s.alu_flags;
    ALUResultE = s.alu; WriteDataE = s.wd; WA3E = s.wa3;
    StallM = s.stall; FlushM = s.flush;
    #1;
    ce = cond_ref(s.cond, s.flags_e);
    check("CondExE", DW'(CondExE), DW'(ce));
    check("BranchTakenE", DW'(BranchTakenE), DW'(s.branch && ce && !s.flush));
    if (s.flush) begin
      model = '{pcsrc: 0, regwrite: 0, memtoreg: 0, memwrite: 0, alu: 0, wd: 0, wa3: 0,
                flags: model.flags};
    end else if (!s.stall) begin
      if (ce) begin
        if (s.fw[1]) model.flags[3:2] = s.alu_flags[3:2];
        if (s.fw[0]) model.flags[1:0] = s.alu_flags[1:0];
      end
      model.pcsrc    = s.pcsrc && ce;
      model.regwrite = s.regwrite && ce;
      model.memwrite = s.memwrite && ce;
      model.memtoreg = s.memtoreg;
      model.alu      = s.alu;
      model.wd       = s.wd;
      model.wa3      = s.wa3;
    end
    exp_q.push_back(model);
  endtask

  initial begin : monitor
    mstate_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("PCSrcM", DW'(PCSrcM), DW'(e.pcsrc));
        check("RegWriteM", DW'(RegWriteM), DW'(e.regwrite));
        check("MemtoRegM", DW'(MemtoRegM), DW'(e.memtoreg));
        check("MemWriteM", DW'(MemWriteM), DW'(e.memwrite));
        check("ALUResultM", ALUResultM, e.alu);
        check("WriteDataM", WriteDataM, e.wd);
        check("WA3M", DW'(WA3M), DW'(e.wa3));
        check("Flags", DW'(Flags), DW'(e.flags));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, DW'({PCSrcM, RegWriteM, MemtoRegM, MemWriteM}), '0);
    check({tag, "_alu"}, ALUResultM, '0);
    check({tag, "_wd"}, WriteDataM, '0);
    check({tag, "_wa3_flags"}, DW'({WA3M, Flags}), '0);
  endtask

  initial begin : driver
    stim_t s;
    model = '0;
    s = idle();
    {PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE} = '0;
    FlagWriteE = 0; CondE = 4'hE; FlagsE = 0; ALUFlags = 0;
    ALUResultE = 0; WriteDataE = 0; WA3E = 0; StallM = 0; FlushM = 0;
    #1 reset = 1'b1;
    #2 check_all_zero("reset_init");

    // Flag writes: N,Z then C,V
    s = idle(); s.fw = 2'b10; s.alu_flags = 4'b1111; step(s);
    @(posedge clk); #2 check("flags_nz", DW'(Flags), DW'(4'b1100));
    s.fw = 2'b01; step(s);
    @(posedge clk); #2 check("flags_cv", DW'(Flags), DW'(4'b1111));

    // EQ passes and fails
    s = idle(); s.cond = 4'h0; s.flags_e = 4'b0100; s.regwrite = 1; s.wa3 = 4'd5; step(s);
    s.flags_e = 4'b0000; step(s);

    // Full condition sweep
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++) begin
        s = idle(); s.cond = 4'(c); s.flags_e = 4'(f);
        s.regwrite = 1; s.memwrite = 1; s.pcsrc = 1; s.branch = 1;
        s.fw = 2'b11; s.alu_flags = 4'(f ^ c); s.alu = $urandom; s.wa3 = 4'(c);
        step(s);
      end

    // Store held across a 3-cycle stall, then flushed while stalled
    s = idle(); s.memwrite = 1; s.fw = 2'b11; s.alu_flags = 4'b0110; step(s);
    s.stall = 1; s.alu_flags = 4'b1001; s.memwrite = 0;
    repeat (3) step(s);
    s.flush = 1; step(s);

    // Branch taken, then killed by flush
    s = idle(); s.branch = 1; s.pcsrc = 1; s.cond = 4'h1; s.flags_e = 4'b0000; step(s);
    s.flush = 1; step(s);

    // Reset between edges discards the in-flight load
    s = idle(); s.fw = 2'b11; s.alu_flags = 4'b1010; step(s);
    s = idle(); s.alu = 32'hDEADBEEF; step(s);
    s = idle(); s.alu = 32'h12345678; s.regwrite = 1; step(s);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid");
    void'(exp_q.pop_back());
    model = '0;
    exp_q.push_back(model);
    s = idle(); s.alu = 32'hCAFEF00D; s.wa3 = 4'd9; s.memtoreg = 1; step(s);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = stim_t'({$urandom, $urandom, $urandom});
      s.alu = $urandom; s.wd = $urandom;
      s.stall = ($urandom_range(0, 5) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      step(s);
    end

    repeat (3) @(posedge clk);
    #2 check("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
